// File: rtl/raw_stream_pkg.sv
// Shared definitions for the 4-pixel-per-clock raw Bayer stream.
// Pattern encodings and the flat Bayer test levels live here.
package raw_stream_pkg;

  localparam int unsigned PIX_WIDTH   = 10;
  localparam int unsigned PIX_PER_CLK = 4;

  typedef enum logic [1:0] {
    PAT_FLAT  = 2'd0,
    PAT_HRAMP = 2'd1,
    PAT_VRAMP = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } gen_state_e;

  localparam logic [PIX_WIDTH-1:0] BAYER_B  = 10'h100;
  localparam logic [PIX_WIDTH-1:0] BAYER_G1 = 10'h180;
  localparam logic [PIX_WIDTH-1:0] BAYER_G2 = 10'h180;
  localparam logic [PIX_WIDTH-1:0] BAYER_R  = 10'h300;

endpackage

// File: rtl/raw_stream_pattern_gen_if.sv
// Raw pixel stream handshake bundle (AXI-Stream style, user=SOF, last=EOL).
interface raw_stream_pattern_gen_if #(
  parameter int unsigned DATA_WIDTH = 40
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_user;
  logic                  out_last;
  logic                  out_ready;

  modport master (output out_data, out_valid, out_user, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_user, out_last, output out_ready);
endinterface

// File: rtl/raw_pattern_pixel.sv
// Combinational pattern lookup: beat contents for position (x, y) and pattern.
// Lane 0 is the leftmost pixel and sits in the most significant field.
module raw_pattern_pixel
  import raw_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned XW         = 9,
  parameter int unsigned YW         = 11
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  pattern_e              pat,
  output logic [DATA_WIDTH-1:0] beat
);

  logic [PIX_WIDTH-1:0] v;
  logic                 chk;

  always_comb begin
    beat = '0;
    v    = '0;
    chk  = ((32'(x) ^ 32'(y)) & 32'd8) != 32'd0;
    for (int unsigned k = 0; k < PIX_PER_CLK; k++) begin
      unique case (pat)
        PAT_FLAT:  v = (k == 0) ? BAYER_B : (k == 1) ? BAYER_G1 : (k == 2) ? BAYER_G2 : BAYER_R;
        // 4*x + k is simply x with the lane index appended
        PAT_HRAMP: v = PIX_WIDTH'({x, 2'(k)});
        PAT_VRAMP: v = PIX_WIDTH'(y);
        default:   v = chk ? '1 : '0;
      endcase
      beat[DATA_WIDTH-1-k*PIX_WIDTH -: PIX_WIDTH] = v;
    end
  end

endmodule

// File: rtl/raw_stream_pattern_gen.sv
// Synthetic raw Bayer frame source with programmable blanking and full backpressure.
// Outputs are registered from next-state values, so a stall simply re-registers the same beat.
module raw_stream_pattern_gen
  import raw_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned PIX_WIDTH  = 10,
  parameter int unsigned H_BEATS    = 480,
  parameter int unsigned V_LINES    = 1080,
  parameter int unsigned H_BLANK    = 16,
  parameter int unsigned V_BLANK    = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  raw_stream_pattern_gen_if.master    m_axis,
  output logic                        frame_done,
  output logic [15:0]                 frame_count
);

  localparam int unsigned XW = (H_BEATS > 1) ? $clog2(H_BEATS) : 1;
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_BEATS - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_LINES - 1);
  localparam logic [15:0]   HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0]   VB_LAST = 16'(V_BLANK - 1);

  gen_state_e     state, state_n;
  logic [XW-1:0]  x, x_n;
  logic [YW-1:0]  y, y_n;
  logic [15:0]    cnt, cnt_n;
  pattern_e       pat, pat_n;
  logic           last_beat;
  logic [DATA_WIDTH-1:0] beat_n;

  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    cnt_n     = cnt;
    pat_n     = pat;
    last_beat = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_ACTIVE;
          x_n     = '0;
          y_n     = '0;
          pat_n   = pattern_e'(pattern_sel);
        end
      end
      ST_ACTIVE: begin
        if (m_axis.out_ready) begin
          if (x != X_LAST) begin
            x_n = x + 1'b1;
          end else begin
            x_n   = '0;
            cnt_n = '0;
            if (y != Y_LAST) begin
              y_n = y + 1'b1;
              if (H_BLANK != 0) state_n = ST_HBLANK;
            end else begin
              last_beat = 1'b1;
              y_n       = '0;
              // zero vertical blanking folds the end-of-frame decision into this edge
              if (V_BLANK != 0)  state_n = ST_VBLANK;
              else if (enable)   pat_n   = pattern_e'(pattern_sel);
              else               state_n = ST_IDLE;
            end
          end
        end
      end
      ST_HBLANK: begin
        if (cnt == HB_LAST) begin
          state_n = ST_ACTIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        if (cnt == VB_LAST) begin
          cnt_n = '0;
          x_n   = '0;
          y_n   = '0;
          if (enable) begin
            state_n = ST_ACTIVE;
            pat_n   = pattern_e'(pattern_sel);
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  raw_pattern_pixel #(
    .DATA_WIDTH (DATA_WIDTH),
    .XW         (XW),
    .YW         (YW)
  ) u_pixel (
    .x    (x_n),
    .y    (y_n),
    .pat  (pat_n),
    .beat (beat_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      x                <= '0;
      y                <= '0;
      cnt              <= '0;
      pat              <= PAT_FLAT;
      m_axis.out_data  <= '0;
      m_axis.out_valid <= 1'b0;
      m_axis.out_user  <= 1'b0;
      m_axis.out_last  <= 1'b0;
      frame_done       <= 1'b0;
      frame_count      <= '0;
    end else begin
      state            <= state_n;
      x                <= x_n;
      y                <= y_n;
      cnt              <= cnt_n;
      pat              <= pat_n;
      m_axis.out_data  <= beat_n;
      m_axis.out_valid <= (state_n == ST_ACTIVE);
      m_axis.out_user  <= (state_n == ST_ACTIVE) && (x_n == '0) && (y_n == '0);
      m_axis.out_last  <= (state_n == ST_ACTIVE) && (x_n == X_LAST);
      frame_done       <= last_beat;
      if (last_beat) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_raw_stream_pattern_gen.sv
// Scoreboard bench for raw_stream_pattern_gen with a 4x3-beat frame,
// plus a second instance with zero blanking for continuous streaming and mid-frame reset.
module tb_raw_stream_pattern_gen;

  localparam int HB = 4;
  localparam int VL = 3;

  typedef struct packed {
    logic [39:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, enable, frame_done;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_count;
  logic        rstn0, enable0, frame_done0;
  logic [1:0]  sel0;
  logic [15:0] frame_count0;

  raw_stream_pattern_gen_if #(.DATA_WIDTH(40)) s  ();
  raw_stream_pattern_gen_if #(.DATA_WIDTH(40)) s0 ();

  raw_stream_pattern_gen #(
    .DATA_WIDTH(40), .PIX_WIDTH(10), .H_BEATS(HB), .V_LINES(VL), .H_BLANK(2), .V_BLANK(3)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .pattern_sel(pattern_sel),
    .m_axis(s), .frame_done(frame_done), .frame_count(frame_count)
  );

  raw_stream_pattern_gen #(
    .DATA_WIDTH(40), .PIX_WIDTH(10), .H_BEATS(HB), .V_LINES(VL), .H_BLANK(0), .V_BLANK(0)
  ) dut0 (
    .clk(clk), .rstn(rstn0), .enable(enable0), .pattern_sel(sel0),
    .m_axis(s0), .frame_done(frame_done0), .frame_count(frame_count0)
  );

  int          tests = 0;
  int          fails = 0;
  int          beats_seen = 0;
  logic [15:0] exp_fc = '0;
  beat_t       exp_q[$];

  function automatic beat_t model(int pat, int x, int y);
    logic [9:0] ln [0:3];
    beat_t m;
    for (int k = 0; k < 4; k++) begin
      case (pat)
        0:       ln[k] = (k == 0) ? 10'h100 : (k == 3) ? 10'h300 : 10'h180;
        1:       ln[k] = 10'(4 * x + k);
        2:       ln[k] = 10'(y);
        default: ln[k] = (((x ^ y) & 8) != 0) ? 10'h3FF : 10'h000;
      endcase
    end
    m.d = {ln[0], ln[1], ln[2], ln[3]};
    m.u = (x == 0) && (y == 0);
    m.l = (x == HB - 1);
    return m;
  endfunction

  task automatic push_frame(input int pat);
    for (int y = 0; y < VL; y++)
      for (int x = 0; x < HB; x++)
        exp_q.push_back(model(pat, x, y));
  endtask

  // scoreboard consumer and stall-stability monitor for the blanking instance
  logic  stall_prev = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (!(s.out_valid && ({s.out_data, s.out_user, s.out_last} == held))) begin
          fails++;
          $display("FAIL stall_hold: got v=%b %h/%b/%b required v=1 %h/%b/%b",
                   s.out_valid, s.out_data, s.out_user, s.out_last, held.d, held.u, held.l);
        end
      end
      if (s.out_valid && s.out_ready) begin
        beat_t e;
        beats_seen++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_extra: got %h/%b/%b required no beat", s.out_data, s.out_user, s.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({s.out_data, s.out_user, s.out_last} !== e) begin
            fails++;
            $display("FAIL beat_%0d: got %h/%b/%b required %h/%b/%b", beats_seen,
                     s.out_data, s.out_user, s.out_last, e.d, e.u, e.l);
          end
        end
      end
      stall_prev = s.out_valid && !s.out_ready;
      held = {s.out_data, s.out_user, s.out_last};
    end
  end

  task automatic wait_beats(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (beats_seen >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fc(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_count == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; pattern_sel = 2'd0; s.out_ready = 1'b1;
    rstn0 = 1'b0; enable0 = 1'b0; sel0 = 2'd0; s0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({s.out_data, s.out_valid, s.out_user, s.out_last, frame_done} !== 44'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", {s.out_data, s.out_valid, s.out_user, s.out_last, frame_done});
    end
    tests++;
    if (frame_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d required 0", frame_count);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (s.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid: got %b required 0", s.out_valid);
    end
  endtask

  task automatic test_flat();
    int  pulses = 0;
    bit  ev;
    pattern_sel = 2'd0;
    push_frame(0);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      ev = (i < 4) || (i >= 6 && i < 10) || (i >= 12 && i < 16);
      tests++;
      if (s.out_valid !== ev) begin
        fails++;
        $display("FAIL flat_valid_c%0d: got %b required %b", i, s.out_valid, ev);
      end
      if (frame_done) pulses++;
      if (i == 16) begin
        tests++;
        if (frame_done !== 1'b1) begin
          fails++;
          $display("FAIL flat_done_timing: got %b required 1", frame_done);
        end
      end
    end
    exp_fc = exp_fc + 16'd1;
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL flat_done_pulses: got %0d required 1", pulses);
    end
    tests++;
    if (frame_count !== exp_fc) begin
      fails++;
      $display("FAIL flat_count: got %0d required %0d", frame_count, exp_fc);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL flat_drain: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_hramp();
    bit ok;
    pattern_sel = 2'd1;
    push_frame(1);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    exp_fc = exp_fc + 16'd1;
    wait_fc(exp_fc, 100, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hramp_timeout: got count %0d required %0d", frame_count, exp_fc);
    end
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL hramp_drain: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    pattern_sel = 2'd2;
    push_frame(2);
    @(posedge clk); #1 enable = 1'b1; s.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1 enable = 1'b0;
    exp_fc = exp_fc + 16'd1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1 s.out_ready = 1'($urandom_range(0, 1));
      if (frame_count == exp_fc) begin ok = 1'b1; break; end
    end
    s.out_ready = 1'b1;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_timeout: got count %0d required %0d", frame_count, exp_fc);
    end
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_stop_reselect();
    bit ok;
    int base;
    bit seen_valid;
    // stop: enable dropped after beat 5 still yields the whole frame
    base = beats_seen;
    pattern_sel = 2'd1;
    push_frame(1);
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(base + 5, 50, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stop_start: got %0d beats required %0d", beats_seen - base, 5); end
    @(posedge clk); #1 enable = 1'b0; pattern_sel = 2'd2;
    exp_fc = exp_fc + 16'd1;
    wait_fc(exp_fc, 100, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stop_timeout: got count %0d required %0d", frame_count, exp_fc); end
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (s.out_valid) seen_valid = 1'b1;
    end
    tests++;
    if (seen_valid !== 1'b0) begin fails++; $display("FAIL stop_idle: got valid 1 required 0"); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL stop_drain: got %0d left required 0", exp_q.size()); end

    // reselect: a mid-frame pattern change applies only to the next frame
    base = beats_seen;
    pattern_sel = 2'd2;
    push_frame(2);
    push_frame(0);
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(base + 5, 50, ok);
    @(posedge clk); #1 pattern_sel = 2'd0;
    wait_beats(base + 13, 100, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL reselect_progress: got %0d beats required %0d", beats_seen - base, 13); end
    @(posedge clk); #1 enable = 1'b0;
    exp_fc = exp_fc + 16'd2;
    wait_fc(exp_fc, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL reselect_timeout: got count %0d required %0d", frame_count, exp_fc); end
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s.out_valid) seen_valid = 1'b1;
    end
    tests++;
    if (seen_valid !== 1'b0) begin fails++; $display("FAIL reselect_idle: got valid 1 required 0"); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL reselect_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_zero_blank_reset();
    bit    ok = 1'b0;
    beat_t e;
    @(posedge clk); #1 rstn0 = 1'b1; sel0 = 2'd1; enable0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s0.out_valid) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL zb_start: got valid 0 required 1"); end
    for (int i = 0; i < 30; i++) begin
      e = model(1, i % HB, (i / HB) % VL);
      tests++;
      if ({s0.out_valid, s0.out_data, s0.out_user, s0.out_last} !== {1'b1, e}) begin
        fails++;
        $display("FAIL zb_beat_%0d: got v=%b %h/%b/%b required v=1 %h/%b/%b", i,
                 s0.out_valid, s0.out_data, s0.out_user, s0.out_last, e.d, e.u, e.l);
      end
      @(negedge clk);
    end
    tests++;
    if (frame_count0 !== 16'd2) begin fails++; $display("FAIL zb_count: got %0d required 2", frame_count0); end
    @(posedge clk); #1 rstn0 = 1'b0;
    #1;
    tests++;
    if ({s0.out_data, s0.out_valid, s0.out_user, s0.out_last, frame_done0, frame_count0} !== 60'd0) begin
      fails++;
      $display("FAIL zb_reset: got %h required 0",
               {s0.out_data, s0.out_valid, s0.out_user, s0.out_last, frame_done0, frame_count0});
    end
    #1 rstn0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s0.out_valid) begin ok = 1'b1; break; end
    end
    e = model(1, 0, 0);
    tests++;
    if (!ok || {s0.out_data, s0.out_user, s0.out_last} !== e) begin
      fails++;
      $display("FAIL zb_restart: got v=%b %h/%b/%b required v=1 %h/%b/%b",
               s0.out_valid, s0.out_data, s0.out_user, s0.out_last, e.d, e.u, e.l);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_hramp();
    test_back_to_back();
    test_stop_reselect();
    test_zero_blank_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/raw_stream_pattern_gen.md
# raw_stream_pattern_gen

- Source end of the 4-pixel-per-clock raw Bayer AXI-Stream video bus: generates complete synthetic frames for `noise_reduction_core` and downstream stages.
- Drives `tuser` as start-of-frame and `tlast` as end-of-line.
- Inserts programmable horizontal and vertical blanking.
- Fully honours `out_ready` backpressure, so the filter path can be exercised on silicon without a sensor.

## Interface
- `DATA_WIDTH`, 40: beat width, 4 pixels × `PIX_WIDTH`.
- `PIX_WIDTH`, 10: bits per raw pixel.
- `H_BEATS`, 480: active beats per line (1920 px / 4).
- `V_LINES`, 1080: active lines per frame.
- `H_BLANK`, 16: idle cycles after each line (0 allowed).
- `V_BLANK`, 32: idle cycles after the last line of a frame (0 allowed).
- `clk  in  1`: clock.
- `rstn  in  1`: reset, asynchronous, active-low.
- `enable  in  1`: run request, sampled only at frame boundaries.
- `pattern_sel  in  2`: pattern select, sampled at frame start.
- `out_data  out  DATA_WIDTH`: pixel beat. Pixel 0 (leftmost) is `[39:30]`, pixel 3 is `[9:0]`.
- `out_valid  out  1`: beat valid.
- `out_user  out  1`: start of frame; high on beat x=0, y=0 only.
- `out_last  out  1`: end of line; high on beat x=`H_BEATS`-1 of every line.
- `out_ready  in  1`: sink ready.
- `frame_done  out  1`: one-cycle pulse when the last beat of a frame transfers.
- `frame_count  out  16`: completed frames, wraps 0xFFFF→0.

## Operation
- **FSM states:** IDLE, ACTIVE, HBLANK, VBLANK.
- **IDLE:** `out_valid`=0. If `enable`=1 at an edge, go to ACTIVE, set x=0 and y=0, and latch `pattern_sel`.
- **ACTIVE:** `out_valid`=1. A beat transfers when `out_valid` && `out_ready`.
  - On transfer with x<`H_BEATS`-1: x++.
  - On transfer with x=`H_BEATS`-1 and y<`V_LINES`-1: x=0, y++, go to HBLANK. If `H_BLANK`=0, stay in ACTIVE.
  - On transfer of the last beat (x=`H_BEATS`-1, y=`V_LINES`-1): pulse `frame_done`, increment `frame_count`, go to VBLANK. If `V_BLANK`=0, go straight to the end-of-VBLANK decision.
- **HBLANK:** `out_valid`=0 for exactly `H_BLANK` cycles, then return to ACTIVE.
- **VBLANK:** `out_valid`=0 for exactly `V_BLANK` cycles. Then:
  - if `enable`=1: go to ACTIVE with x=y=0 and re-latch `pattern_sel`;
  - otherwise go to IDLE.
- **enable dropped mid-frame:** the current frame completes in full. Frames are never truncated.
- **Patterns:** lane k = 0..3; value modulo 2^`PIX_WIDTH`.
  - 0, flat Bayer: lanes {0x100, 0x180, 0x180, 0x300}.
  - 1, horizontal ramp: lane k = 4·x + k.
  - 2, vertical ramp: all lanes = y[9:0].
  - 3, checker: all lanes = 0x3FF if x[3]^y[3], else 0x000.
- **AXI-Stream rule:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_user` and `out_last` hold stable. `out_valid` never drops without a transfer.
- **Counters:** x is clog2(`H_BEATS`) bits, y is clog2(`V_LINES`) bits, the blank counter is 16 bits. All are unsigned and reset to 0 at each use.

## Timing
- All outputs are registered.
- **Reset value of every output:** `out_data`=0, `out_valid`=0, `out_user`=0, `out_last`=0, `frame_done`=0, `frame_count`=0. Reset also forces the state to IDLE and clears x, y and the blank counter.
- **Reset mid-frame:** abandons the frame immediately. No partial `tlast` is emitted.
- **Start latency:** `enable` high at edge N in IDLE gives `out_valid`=1 with the first beat (`out_user`=1) after edge N.
- **Throughput:** with `out_ready` held high, one beat per cycle.
  - Each line occupies `H_BEATS`+`H_BLANK` cycles.
  - The last line is followed by `V_BLANK` idle cycles instead of `H_BLANK`.
- **Next beat:** on a transfer edge, the next beat (or `out_valid`=0 for blanking) is presented in the following cycle.
- **frame_done timing:** `frame_done` asserts in the cycle after the final transfer. `frame_count` updates on the same edge.
- **Backpressure:** stalls do not count toward blanking. Blanking begins only after the line's final beat transfers.

## Structure
- **Package `raw_stream_pkg`:**
  - `PIX_WIDTH` and pixels-per-clock (4);
  - the pattern_sel encodings PAT_FLAT, PAT_HRAMP, PAT_VRAMP, PAT_CHECK;
  - the Bayer flat constants B/G1/G2/R = 0x100/0x180/0x180/0x300.
  `noise_reduction_core` reuses this package.
- **Sub-module `raw_pattern_pixel`:** combinational. Takes x, y and the latched select, and returns the `DATA_WIDTH` beat. The generator FSM and counters stay in the top module.

## Test plan
Small parameters: `H_BEATS`=4, `V_LINES`=3, `H_BLANK`=2, `V_BLANK`=3.
- **Flat pattern:** reset, `enable`=1, `pattern_sel`=0, `out_ready`=1 → 12 beats of 0x100_180_180_300 (packed 10-bit fields). `out_user` on beat 0 only; `out_last` on beats 3, 7 and 11. 2 idle cycles between lines and 3 after the frame. `frame_done` pulses once; `frame_count`=1.
- **Horizontal ramp:** `pattern_sel`=1 → line beats carry lanes {0,1,2,3}, {4,5,6,7}, {8,9,10,11}, {12,13,14,15}. Identical on every line.
- **Backpressure:** toggle `out_ready` pseudo-randomly → data, user and last stay stable during stalls. The beat sequence matches the no-stall run, and no beats are lost or duplicated.
- **Stop and reselect:** drop `enable` at beat 5 → the frame completes (12 beats), then `out_valid` stays 0. Change `pattern_sel` mid-frame → takes effect only in the next frame.
- **Zero blanking and mid-frame reset:** `H_BLANK`=0, `V_BLANK`=0, `enable` held → `out_valid` is continuously high across lines and frames. `rstn` pulsed mid-frame → all outputs 0 and `frame_count`=0; the next frame restarts with `out_user`=1.
